// File: rtl/phase1_pkg.sv
// Shared types and display codes for the Phase 1 puzzle chain.
package phase1_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE,
    S_FAIL
  } state_t;

  localparam logic [3:0]  SEG_BLANK     = 4'hF;
  localparam logic [3:0]  SEG_DASH      = 4'hE;
  localparam logic [31:0] SEG_ALL_BLANK = {8{SEG_BLANK}};
  localparam logic [31:0] SEG_ALL_DASH  = {8{SEG_DASH}};

endpackage

// File: rtl/phase1_sequencer_phase_timer.sv
// Saturating up-counter with clear/enable; hit flags the limit value.
module phase_timer #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [W-1:0] TOP = W'(LIMIT);

  logic [W-1:0] count;

  assign hit = (count == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !hit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/phase1_sequencer.sv
// Phase 1 controller: steps puzzles one at a time, muxes their
// display/motor, and enforces the phase time limit.
module phase1_sequencer
  import phase1_pkg::*;
#(
  parameter int N_PUZ       = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int TIME_LIMIT  = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_PUZ-1:0]           puzzle_clear,
  input  logic [N_PUZ*32-1:0]        puzzle_seg,
  input  logic [N_PUZ-1:0]           puzzle_motor,
  output logic [N_PUZ-1:0]           puzzle_enable,
  output logic [31:0]                seg_display,
  output logic                       motor_pulse,
  output logic [$clog2(N_PUZ)-1:0]   stage,
  output logic                       phase_done,
  output logic                       phase_fail
);

  localparam int SW = $clog2(N_PUZ);
  localparam int EW =
    (TIME_LIMIT > 0) ? $clog2(TIME_LIMIT + 1) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [SW-1:0] LAST = SW'(N_PUZ - 1);
  localparam logic [N_PUZ-1:0] ONE = N_PUZ'(1);

  state_t            state, state_n;
  logic [SW-1:0]     stage_n;
  logic              armed, armed_n;
  logic [N_PUZ-1:0]  en_n;
  logic [31:0]       seg_n;
  logic              mot_n, done_n, fail_n;
  logic              el_clr, el_en, el_hit;
  logic              hd_clr, hd_en, hd_hit;
  logic              accept, timeout;
  logic [31:0]       seg_arr [N_PUZ];
  logic [31:0]       seg_sel;
  logic              mot_sel;

  for (genvar i = 0; i < N_PUZ; i++) begin : g_seg
    assign seg_arr[i] = puzzle_seg[32*i +: 32];
  end

  assign seg_sel = seg_arr[stage_n];
  assign mot_sel = puzzle_motor[stage_n];

  // A clear is only trusted once the enable has been up a full cycle.
  assign accept  = (state == S_RUN) && armed
                && puzzle_clear[stage];
  assign timeout = (TIME_LIMIT != 0) && el_hit;

  assign el_en = (state == S_RUN) || (state == S_HOLD);
  assign hd_en = (state == S_HOLD);
  assign hd_clr = (state != S_HOLD) || abort;

  phase_timer #(
    .W     (EW),
    .LIMIT (TIME_LIMIT)
  ) u_elapsed (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (el_clr),
    .en    (el_en),
    .hit   (el_hit)
  );

  phase_timer #(
    .W     (HW),
    .LIMIT (HOLD_CYCLES - 1)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (hd_clr),
    .en    (hd_en),
    .hit   (hd_hit)
  );

  always_comb begin
    state_n = state;
    stage_n = stage;
    armed_n = 1'b0;
    el_clr  = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
      stage_n = '0;
      el_clr  = 1'b1;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            state_n = S_RUN;
            stage_n = '0;
            el_clr  = 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            state_n = S_HOLD;
          end else if (timeout) begin
            state_n = S_FAIL;
          end else begin
            armed_n = 1'b1;
          end
        end
        S_HOLD: begin
          if (hd_hit) begin
            if (stage == LAST) begin
              state_n = S_DONE;
            end else begin
              state_n = S_RUN;
              stage_n = stage + SW'(1);
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    en_n   = puzzle_enable;
    seg_n  = seg_display;
    mot_n  = 1'b0;
    done_n = 1'b0;
    fail_n = 1'b0;
    unique case (state_n)
      S_RUN: begin
        en_n  = ONE << stage_n;
        seg_n = seg_sel;
        mot_n = mot_sel;
      end
      S_HOLD: begin
        seg_n = (state == S_RUN) ? seg_sel : seg_display;
      end
      S_DONE: begin
        en_n   = '0;
        seg_n  = SEG_ALL_BLANK;
        done_n = 1'b1;
      end
      S_FAIL: begin
        en_n   = '0;
        seg_n  = SEG_ALL_DASH;
        fail_n = 1'b1;
      end
      default: begin
        en_n  = '0;
        seg_n = SEG_ALL_BLANK;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      stage         <= '0;
      armed         <= 1'b0;
      puzzle_enable <= '0;
      seg_display   <= SEG_ALL_BLANK;
      motor_pulse   <= 1'b0;
      phase_done    <= 1'b0;
      phase_fail    <= 1'b0;
    end else begin
      state         <= state_n;
      stage         <= stage_n;
      armed         <= armed_n;
      puzzle_enable <= en_n;
      seg_display   <= seg_n;
      motor_pulse   <= mot_n;
      phase_done    <= done_n;
      phase_fail    <= fail_n;
    end
  end

endmodule

// File: tb/tb_phase1_sequencer.sv
// Directed bench for phase1_sequencer with a behavioural reference.
module tb_phase1_sequencer;

  localparam int NP = 4;
  localparam int HC = 4;
  localparam int TL = 50;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start, abort;
  logic [NP-1:0]    puzzle_clear, puzzle_motor;
  logic [NP*32-1:0] puzzle_seg;
  logic [NP-1:0]    puzzle_enable;
  logic [31:0]      seg_display;
  logic             motor_pulse, phase_done, phase_fail;
  logic [1:0]       stage;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  phase1_sequencer #(
    .N_PUZ(NP), .HOLD_CYCLES(HC), .TIME_LIMIT(TL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .puzzle_clear(puzzle_clear), .puzzle_seg(puzzle_seg),
    .puzzle_motor(puzzle_motor), .puzzle_enable(puzzle_enable),
    .seg_display(seg_display), .motor_pulse(motor_pulse),
    .stage(stage), .phase_done(phase_done),
    .phase_fail(phase_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] seg_of(input int i);
    return puzzle_seg[32*i +: 32];
  endfunction

  // Reference model: phase modes, integer counters, plain rules.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE, M_FAIL} mode_t;
  mode_t       m_mode = M_IDLE;
  int          m_stage = 0, m_el = 0, m_hold = 0, m_age = 0;
  logic [NP-1:0] x_en = '0;
  logic [31:0] x_seg = 32'hFFFF_FFFF;
  logic        x_mot = 1'b0, x_done = 1'b0, x_fail = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || abort) begin
      m_mode <= M_IDLE; m_stage <= 0; m_el <= 0;
      m_hold <= 0; m_age <= 0; x_en <= '0;
      x_seg <= 32'hFFFF_FFFF; x_mot <= 1'b0;
      x_done <= 1'b0; x_fail <= 1'b0;
    end else begin
      if (m_mode == M_RUN || m_mode == M_HOLD)
        m_el <= (m_el < TL) ? m_el + 1 : TL;
      case (m_mode)
        M_IDLE, M_DONE, M_FAIL: if (start) begin
          m_mode <= M_RUN; m_stage <= 0; m_el <= 0; m_age <= 0;
          x_en <= 4'b0001; x_seg <= seg_of(0);
          x_mot <= puzzle_motor[0];
          x_done <= 1'b0; x_fail <= 1'b0;
        end
        M_RUN: begin
          if (m_age > 0 && puzzle_clear[m_stage]) begin
            m_mode <= M_HOLD; m_hold <= HC;
            x_seg <= seg_of(m_stage); x_mot <= 1'b0;
          end else if (m_el >= TL) begin
            m_mode <= M_FAIL; x_en <= '0;
            x_seg <= 32'hEEEE_EEEE; x_mot <= 1'b0;
            x_fail <= 1'b1;
          end else begin
            m_age <= m_age + 1;
            x_seg <= seg_of(m_stage);
            x_mot <= puzzle_motor[m_stage];
          end
        end
        M_HOLD: begin
          if (m_hold == 1) begin
            if (m_stage == NP - 1) begin
              m_mode <= M_DONE; x_en <= '0;
              x_seg <= 32'hFFFF_FFFF; x_done <= 1'b1;
            end else begin
              m_mode <= M_RUN; m_stage <= m_stage + 1;
              m_age <= 0;
              x_en <= 4'(1) << (m_stage + 1);
              x_seg <= seg_of(m_stage + 1);
              x_mot <= puzzle_motor[m_stage + 1];
            end
          end else begin
            m_hold <= m_hold - 1;
          end
        end
        default: m_mode <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("enable", 32'(puzzle_enable), 32'(x_en));
      chk("seg", seg_display, x_seg);
      chk("motor", 32'(motor_pulse), 32'(x_mot));
      chk("stage", 32'(stage), 32'(m_stage));
      chk("done", 32'(phase_done), 32'(x_done));
      chk("fail", 32'(phase_fail), 32'(x_fail));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_en"}, 32'(puzzle_enable), 32'h0);
    chk({nm, "_seg"}, seg_display, 32'hFFFF_FFFF);
    chk({nm, "_mot"}, 32'(motor_pulse), 32'h0);
    chk({nm, "_stage"}, 32'(stage), 32'h0);
    chk({nm, "_done"}, 32'(phase_done), 32'h0);
    chk({nm, "_fail"}, 32'(phase_fail), 32'h0);
  endtask

  // Entered at the first RUN cycle of stage i; leaves just after HOLD.
  task automatic run_stage(input int i);
    logic [NP*32-1:0] saved;
    chk("entry_en", 32'(puzzle_enable), 32'(1) << i);
    chk("entry_stage", 32'(stage), 32'(i));
    if (i == 2) begin
      saved = puzzle_seg;
      puzzle_seg = '0;
      puzzle_seg[64 +: 32] = 32'h12FF_FF34;
      puzzle_motor = 4'b0101;
      step();
      chk("mux_seg", seg_display, 32'h12FF_FF34);
      chk("mux_motor_fwd", 32'(motor_pulse), 32'h1);
      puzzle_motor = 4'b0001;
      step();
      chk("mux_motor_drop", 32'(motor_pulse), 32'h0);
      puzzle_motor = '0;
      puzzle_seg = saved;
      puzzle_clear[i] = 1'b1;
      step();
    end else begin
      puzzle_clear[i] = 1'b1;
      step();
      step();
    end
    puzzle_clear[i] = 1'b0;
    for (int h = 0; h < HC; h++) begin
      chk("hold_en", 32'(puzzle_enable), 32'(1) << i);
      step();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b0; abort = 1'b0;
    puzzle_clear = '0; puzzle_motor = '0;
    puzzle_seg = {32'hD3D3_0003, 32'hC2C2_0002,
                  32'hB1B1_0001, 32'hA0A0_0000};
    #1 rst_n = 1'b0;
    repeat (3) step();
    cmp_on = 1'b1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    step();

    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < NP; i++) run_stage(i);
    chk("done_flag", 32'(phase_done), 32'h1);
    chk("done_en", 32'(puzzle_enable), 32'h0);
    chk("done_seg", seg_display, 32'hFFFF_FFFF);

    puzzle_clear[1] = 1'b1; puzzle_motor[1] = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    run_stage(0);
    chk("stale_en", 32'(puzzle_enable), 32'h2);
    chk("stale_mot0", 32'(motor_pulse), 32'h1);
    step();
    chk("stale_ignored", 32'(motor_pulse), 32'h1);
    step();
    chk("stale_accepted", 32'(motor_pulse), 32'h0);
    chk("stale_hold_en", 32'(puzzle_enable), 32'h2);
    puzzle_clear[1] = 1'b0; puzzle_motor = '0;
    abort = 1'b1; step(); abort = 1'b0;
    chk_reset_vals("abort");

    start = 1'b1; step(); start = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    step();
    rst_n = 1'b1;
    step();

    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= TL; k++) begin
      step();
      chk("pre_limit_fail", 32'(phase_fail), 32'h0);
    end
    step();
    chk("to_fail", 32'(phase_fail), 32'h1);
    chk("to_seg", seg_display, 32'hEEEE_EEEE);
    chk("to_en", 32'(puzzle_enable), 32'h0);

    start = 1'b1; step(); start = 1'b0;
    repeat (TL) step();
    puzzle_clear[0] = 1'b1; step(); puzzle_clear[0] = 1'b0;
    chk("tie_no_fail", 32'(phase_fail), 32'h0);
    chk("tie_en", 32'(puzzle_enable), 32'h1);
    puzzle_seg[0 +: 32] = 32'h5555_5555;
    step();
    chk("tie_latched", seg_display, 32'hA0A0_0000);
    puzzle_seg[0 +: 32] = 32'hA0A0_0000;
    repeat (3) step();
    chk("tie_next_en", 32'(puzzle_enable), 32'h2);
    chk("tie_next_fail0", 32'(phase_fail), 32'h0);
    step();
    chk("tie_sat_fail", 32'(phase_fail), 32'h1);

    abort = 1'b1; step(); abort = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
